// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, controller state encoding and road-count legality check
package traffic_pkg;
   typedef enum logic [1:0] {
      L_GREEN  = 2'b00,
      L_YELLOW = 2'b01,
      L_RED    = 2'b10
   } light_e;
   typedef enum logic [1:0] {
      S_GREEN  = 2'b00,
      S_YELLOW = 2'b01,
      S_ALLRED = 2'b10,
      S_WALK   = 2'b11
   } state_e;
   localparam int MIN_ROADS = 2;
   localparam int MAX_ROADS = 8;
   function automatic bit roads_ok(input int n);
      return n >= MIN_ROADS && n <= MAX_ROADS;
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating elapsed-cycle counter, cleared on phase entry, flags when limit reached
module phase_timer #(
   parameter int CNT_W = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             done_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // count up from zero after entry, holding at all-ones instead of wrapping
   always_comb cnt_d = clr_i ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   // elapsed-cycle register
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   // count k is shown in the (k+1)-th cycle of a phase, so the last cycle sees limit-1
   assign done_o = cnt_q >= limit_i - 1'b1;
endmodule

// File: rtl/traffic_light_ctrl_multi.sv
// traffic_light_ctrl_multi: round-robin multi-road light controller; TRAFFIC_PED_WALK_EN adds a pedestrian walk phase
module traffic_light_ctrl_multi
   import traffic_pkg::*;
#(
   parameter int NUM_ROADS    = 4,
   parameter int CNT_W        = 30,
   parameter int GREEN_TICKS  = 500000000,
   parameter int YELLOW_TICKS = 200000000,
   parameter int ALLRED_TICKS = 50000000
`ifdef TRAFFIC_PED_WALK_EN
   ,
   parameter int WALK_TICKS   = 300000000
`endif
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_ROADS-1:0]         sensor,
`ifdef TRAFFIC_PED_WALK_EN
   input  logic                         ped_req,
   output logic                         walk,
`endif
   output logic [2*NUM_ROADS-1:0]       lights,
   output logic [$clog2(NUM_ROADS)-1:0] active_road,
   output logic [1:0]                   phase
);
   localparam int AW = $clog2(NUM_ROADS);
   localparam logic [2*NUM_ROADS-1:0] RST_LIGHTS = {{(NUM_ROADS-1){2'(L_RED)}}, 2'(L_GREEN)};
`ifdef TRAFFIC_PED_WALK_EN
   localparam logic [CNT_W-1:0] WALK_LIM = CNT_W'(WALK_TICKS);
`else
   localparam logic [CNT_W-1:0] WALK_LIM = CNT_W'(ALLRED_TICKS);
`endif

   if (!roads_ok(NUM_ROADS)) begin : g_bad_roads
      $error("NUM_ROADS must lie in 2..8");
   end

   state_e                 state_q, state_d;
   logic [AW-1:0]          act_q, act_d, tgt_q, tgt_d, pick;
   logic [2*NUM_ROADS-1:0] lights_q, lights_d;
   logic [CNT_W-1:0]       limit;
   logic                   found, done, go;

`ifdef TRAFFIC_PED_WALK_EN
   logic pend_q, pend_d, walk_q;
   // a pending walk also ends green; it clears only as the walk phase finishes
   always_comb begin
      pend_d = ((state_q == S_WALK && done) ? 1'b0 : pend_q) | ped_req;
      go     = found | pend_q;
   end
   // pending-walk flag and registered walk indicator
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pend_q <= 1'b0;
         walk_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         walk_q <= state_d == S_WALK;
      end
   assign walk = walk_q;
`else
   // only another road's request ends green
   always_comb go = found;
`endif

   // first requesting road after the active one in round-robin order; descending scan so nearest wins
   always_comb begin
      found = 1'b0;
      pick  = act_q;
      for (int k = NUM_ROADS - 1; k >= 1; k--)
         if (sensor[(int'(act_q) + k) % NUM_ROADS]) begin
            found = 1'b1;
            pick  = AW'((int'(act_q) + k) % NUM_ROADS);
         end
   end

   // duration of the phase currently running
   always_comb limit = state_q == S_GREEN  ? CNT_W'(GREEN_TICKS)  :
                       state_q == S_YELLOW ? CNT_W'(YELLOW_TICKS) :
                       state_q == S_ALLRED ? CNT_W'(ALLRED_TICKS) : WALK_LIM;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (state_d != state_q),
      .limit_i (limit),
      .done_o  (done)
   );

   // next state, target latch on green exit, handover of green at the end of clearance
   always_comb begin
      state_d = state_q;
      act_d   = act_q;
      tgt_d   = tgt_q;
      case (state_q)
         S_GREEN:  if (done && go) begin
            state_d = S_YELLOW;
            tgt_d   = pick;
         end
         S_YELLOW: if (done) state_d = S_ALLRED;
         S_ALLRED: if (done) begin
`ifdef TRAFFIC_PED_WALK_EN
            if (pend_q) state_d = S_WALK;
            else begin
               state_d = S_GREEN;
               act_d   = tgt_q;
            end
`else
            state_d = S_GREEN;
            act_d   = tgt_q;
`endif
         end
         default:  if (done) begin
            state_d = S_GREEN;
            act_d   = tgt_q;
         end
      endcase
   end

   // light pattern for the coming cycle; only the active road can be non-red
   always_comb begin
      lights_d = RST_LIGHTS;
      for (int i = 0; i < NUM_ROADS; i++)
         lights_d[2*i +: 2] = (act_d != AW'(i))    ? L_RED    :
                              (state_d == S_GREEN)  ? L_GREEN  :
                              (state_d == S_YELLOW) ? L_YELLOW : L_RED;
   end

   // controller state, ownership, target and registered lights
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q  <= S_GREEN;
         act_q    <= '0;
         tgt_q    <= '0;
         lights_q <= RST_LIGHTS;
      end else begin
         state_q  <= state_d;
         act_q    <= act_d;
         tgt_q    <= tgt_d;
         lights_q <= lights_d;
      end

   assign lights      = lights_q;
   assign active_road = act_q;
   assign phase       = state_q;
endmodule
